// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the scalar pipeline. It sits behind the EX/MEM
// register, performs loads and stores over a variable-latency req/ack data
// memory port, stalls the upstream pipeline while an access is outstanding,
// and holds the MEM/WB pipeline register that feeds writeback.
//
// All state updates happen on the falling edge of CLK. CLR is asynchronous
// and active-high and clears every register, including the W bundle and the
// memory port latches.
//
// Ports
//   CLK, CLR                 clock (falling edge) / async reset
//   REG_WRITE_M              M-stage register-write enable
//   MEM_TO_REG_M             M-stage load select
//   MEM_WRITE_M              M-stage store select (wins over MEM_TO_REG_M)
//   ALU_OUT_M                address for memory ops, result for ALU ops
//   WRITE_DATA_M             store data
//   WRITE_REG_M              destination register
//   MEM_REQ/MEM_WE           registered request / store flag
//   MEM_ADDR/MEM_WDATA       latched address / store data, valid with MEM_REQ
//   MEM_ACK/MEM_RDATA        completion strobe / load data (ACCESS only)
//   STALL_M                  freeze F/D/E and the EX/MEM register
//   REG_WRITE_W, MEM_TO_REG_W, ALU_OUT_W, READ_DATA_W, WRITE_REG_W
//                            W-stage bundle
//   ERR                      sticky access-timeout flag
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int WIDTH   = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             REG_WRITE_M,
    input  logic             MEM_TO_REG_M,
    input  logic             MEM_WRITE_M,
    input  logic [WIDTH-1:0] ALU_OUT_M,
    input  logic [WIDTH-1:0] WRITE_DATA_M,
    input  logic [REG_W-1:0] WRITE_REG_M,
    output logic             MEM_REQ,
    output logic             MEM_WE,
    output logic [WIDTH-1:0] MEM_ADDR,
    output logic [WIDTH-1:0] MEM_WDATA,
    input  logic             MEM_ACK,
    input  logic [WIDTH-1:0] MEM_RDATA,
    output logic             STALL_M,
    output logic             REG_WRITE_W,
    output logic             MEM_TO_REG_W,
    output logic [WIDTH-1:0] ALU_OUT_W,
    output logic [WIDTH-1:0] READ_DATA_W,
    output logic [REG_W-1:0] WRITE_REG_W,
    output logic             ERR
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [CNT_W-1:0] cnt;
    logic             aborted_p1;   // current op ended by timeout
    logic [WIDTH-1:0] rdata_p1;     // load data captured on ack

    logic             mem_op;
    logic             start_op;     // IDLE edge that launches a request
    logic             ack_take;     // ACCESS edge with ack present
    logic             tmo_hit;      // ACCESS edge that gives up
    logic             w_capture;    // W register takes the M bundle
    logic             w_abort;      // W capture of an aborted op

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-edge decisions. MEM_ACK only matters in ACCESS,
    // and an ack on the last permitted edge still counts as success.
    always_comb begin
        state_n   = state;
        mem_op    = MEM_TO_REG_M | MEM_WRITE_M;
        start_op  = 1'b0;
        ack_take  = 1'b0;
        tmo_hit   = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        STALL_M   = 1'b0;

        case (state)
            S_IDLE: begin
                if (mem_op) begin
                    start_op = 1'b1;
                    state_n  = S_ACCESS;
                end else begin
                    w_capture = 1'b1;
                end
            end
            S_ACCESS: begin
                if (MEM_ACK) begin
                    ack_take = 1'b1;
                    state_n  = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    tmo_hit = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_capture = 1'b1;
                w_abort   = aborted_p1;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Released in DONE so the next instruction moves up on the same
        // edge that the W register takes the finished one.
        STALL_M = mem_op & (state != S_DONE);
    end

    // -----------------------------------------------------------------
    // Memory port, timeout counter and captured load data
    // -----------------------------------------------------------------
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            MEM_REQ    <= 1'b0;
            MEM_WE     <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
            cnt        <= '0;
            aborted_p1 <= 1'b0;
            rdata_p1   <= '0;
            ERR        <= 1'b0;
        end else begin
            if (start_op) begin
                MEM_REQ    <= 1'b1;
                MEM_WE     <= MEM_WRITE_M;
                MEM_ADDR   <= ALU_OUT_M;
                MEM_WDATA  <= WRITE_DATA_M;
                cnt        <= '0;
                aborted_p1 <= 1'b0;
                rdata_p1   <= '0;
            end else if (ack_take) begin
                MEM_REQ  <= 1'b0;
                // Stores (including load+store, where the store wins)
                // never return data.
                rdata_p1 <= MEM_WE ? '0 : MEM_RDATA;
            end else if (tmo_hit) begin
                MEM_REQ    <= 1'b0;
                aborted_p1 <= 1'b1;
                ERR        <= 1'b1;
            end else if (state == S_ACCESS) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------
    // MEM/WB pipeline register
    // -----------------------------------------------------------------
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            REG_WRITE_W  <= 1'b0;
            MEM_TO_REG_W <= 1'b0;
            ALU_OUT_W    <= '0;
            READ_DATA_W  <= '0;
            WRITE_REG_W  <= '0;
        end else if (w_capture) begin
            REG_WRITE_W  <= REG_WRITE_M & ~w_abort;
            MEM_TO_REG_W <= MEM_TO_REG_M;
            ALU_OUT_W    <= ALU_OUT_M;
            WRITE_REG_W  <= WRITE_REG_M;
            // Only a completed access in DONE carries read data.
            READ_DATA_W  <= ((state == S_DONE) && !aborted_p1) ? rdata_p1 : '0;
        end else begin
            // Bubble while an access launches or is outstanding.
            REG_WRITE_W  <= 1'b0;
            MEM_TO_REG_W <= 1'b0;
            ALU_OUT_W    <= '0;
            READ_DATA_W  <= '0;
            WRITE_REG_W  <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Bench for mem_stage. Each instruction is turned into a cycle-level
// expectation by a transaction model: a memory op whose memory answers after
// k access cycles occupies min(k,TIMEOUT)+2 cycles, stalls for all but the
// last, and writes back its bundle on the last edge; edges before that show
// bubbles. Expected W bundles go into a queue that a monitor drains once per
// falling edge. A memory responder answers requests with a chosen latency
// and toggles MEM_ACK at random while no request is pending.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam int WIDTH   = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 4;

    logic             CLK = 1'b0;
    logic             CLR;
    logic             REG_WRITE_M, MEM_TO_REG_M, MEM_WRITE_M;
    logic [WIDTH-1:0] ALU_OUT_M, WRITE_DATA_M;
    logic [REG_W-1:0] WRITE_REG_M;
    logic             MEM_REQ, MEM_WE;
    logic [WIDTH-1:0] MEM_ADDR, MEM_WDATA;
    logic             MEM_ACK;
    logic [WIDTH-1:0] MEM_RDATA;
    logic             STALL_M;
    logic             REG_WRITE_W, MEM_TO_REG_W;
    logic [WIDTH-1:0] ALU_OUT_W, READ_DATA_W;
    logic [REG_W-1:0] WRITE_REG_W;
    logic             ERR;

    mem_stage #(.WIDTH(WIDTH), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .CLR(CLR),
        .REG_WRITE_M(REG_WRITE_M), .MEM_TO_REG_M(MEM_TO_REG_M),
        .MEM_WRITE_M(MEM_WRITE_M), .ALU_OUT_M(ALU_OUT_M),
        .WRITE_DATA_M(WRITE_DATA_M), .WRITE_REG_M(WRITE_REG_M),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .STALL_M(STALL_M), .REG_WRITE_W(REG_WRITE_W),
        .MEM_TO_REG_W(MEM_TO_REG_W), .ALU_OUT_W(ALU_OUT_W),
        .READ_DATA_W(READ_DATA_W), .WRITE_REG_W(WRITE_REG_W), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic             rw;
        logic             mtr;
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] rd;
        logic [REG_W-1:0] wr;
    } wb_t;

    wb_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   sb_en    = 0;
    bit   resp_en  = 0;
    bit   err_exp  = 0;

    // Shared with the responder: what the current request must look like
    // and how the memory should answer it.
    int               resp_k    = 1;
    logic [WIDTH-1:0] resp_data = '0;
    logic [WIDTH-1:0] exp_addr  = '0;
    logic [WIDTH-1:0] exp_wdata = '0;
    logic             exp_we    = 1'b0;
    int               req_pulses = 0;
    int               mem_ops    = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: one W bundle per falling edge.
    initial begin
        wb_t got, exp;
        forever begin
            @(negedge CLK);
            #1;
            if (sb_en && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = '{rw: REG_WRITE_W, mtr: MEM_TO_REG_W, alu: ALU_OUT_W,
                        rd: READ_DATA_W, wr: WRITE_REG_W};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL w_bundle at %0t: got rw=%0b mtr=%0b alu=%08h rd=%08h wr=%0d expected rw=%0b mtr=%0b alu=%08h rd=%08h wr=%0d",
                             $time, got.rw, got.mtr, got.alu, got.rd, got.wr,
                             exp.rw, exp.mtr, exp.alu, exp.rd, exp.wr);
                end
            end
        end
    end

    // Memory responder.
    initial begin
        int acc_cyc = 0;
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
        forever begin
            @(posedge CLK);
            if (resp_en) begin
                if (MEM_REQ) begin
                    acc_cyc++;
                    if (acc_cyc == 1) req_pulses++;
                    chk("mem_addr", MEM_ADDR, exp_addr);
                    chk("mem_we", WIDTH'(MEM_WE), WIDTH'(exp_we));
                    chk("mem_wdata", MEM_WDATA, exp_wdata);
                    if (acc_cyc == resp_k) begin
                        MEM_ACK   = 1'b1;
                        MEM_RDATA = resp_data;
                    end else begin
                        MEM_ACK   = 1'b0;
                        MEM_RDATA = $urandom;
                    end
                end else begin
                    acc_cyc   = 0;
                    MEM_ACK   = 1'($urandom_range(0, 1));
                    MEM_RDATA = $urandom;
                end
            end
        end
    end

    // Present one instruction and hold it for as long as the model says the
    // stage is busy with it; k = memory latency in access cycles.
    task automatic issue(input logic rw, input logic mtr, input logic mw,
                         input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] wd,
                         input logic [REG_W-1:0] wr, input int k,
                         input logic [WIDTH-1:0] rd);
        bit  memop   = mtr | mw;
        bit  aborted = memop && (k > TIMEOUT);
        int  kk      = aborted ? TIMEOUT : k;
        int  ncyc    = memop ? kk + 2 : 1;
        bit  is_load = mtr && !mw;
        wb_t res;
        res.rw  = rw && !aborted;
        res.mtr = mtr;
        res.alu = alu;
        res.wr  = wr;
        res.rd  = (memop && is_load && !aborted) ? rd : '0;

        @(posedge CLK);
        REG_WRITE_M  = rw;
        MEM_TO_REG_M = mtr;
        MEM_WRITE_M  = mw;
        ALU_OUT_M    = alu;
        WRITE_DATA_M = wd;
        WRITE_REG_M  = wr;
        resp_k    = k;
        resp_data = rd;
        exp_addr  = alu;
        exp_wdata = wd;
        exp_we    = mw;
        if (memop) mem_ops++;
        for (int i = 1; i < ncyc; i++) exp_q.push_back('0);
        exp_q.push_back(res);

        for (int i = 1; i <= ncyc; i++) begin
            if (i > 1) @(posedge CLK);
            #1;
            if (aborted && i == ncyc) err_exp = 1;
            chk("stall_m", WIDTH'(STALL_M), WIDTH'(i < ncyc));
            chk("err", WIDTH'(ERR), WIDTH'(err_exp));
        end
    endtask

    task automatic check_w_zero(input string tag);
        chk({tag, "_rw"},  WIDTH'(REG_WRITE_W), '0);
        chk({tag, "_mtr"}, WIDTH'(MEM_TO_REG_W), '0);
        chk({tag, "_alu"}, ALU_OUT_W, '0);
        chk({tag, "_rd"},  READ_DATA_W, '0);
        chk({tag, "_wr"},  WIDTH'(WRITE_REG_W), '0);
    endtask

    task automatic zero_m();
        REG_WRITE_M  = 1'b0;
        MEM_TO_REG_M = 1'b0;
        MEM_WRITE_M  = 1'b0;
        ALU_OUT_M    = '0;
        WRITE_DATA_M = '0;
        WRITE_REG_M  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        CLR = 1'b1;
        zero_m();
        #12;
        // Reset state.
        chk("rst_req", WIDTH'(MEM_REQ), '0);
        chk("rst_we", WIDTH'(MEM_WE), '0);
        chk("rst_addr", MEM_ADDR, '0);
        chk("rst_err", WIDTH'(ERR), '0);
        chk("rst_stall", WIDTH'(STALL_M), '0);
        check_w_zero("rst_w");
        @(posedge CLK);
        CLR     = 1'b0;
        resp_en = 1;
        sb_en   = 1;

        // Directed cases.
        issue(1'b1, 1'b0, 1'b0, 32'h0000_00AA, 32'h0, 5'd3, 1, 32'h0);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1, 32'hDEAD_BEEF);
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd0, 4, 32'h0);
        issue(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 5'd9, 2, 32'h5555_AAAA);
        // Back-to-back load then store.
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd4, 1, 32'h0BAD_CAFE);
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h8765_4321, 5'd0, 1, 32'h0);
        // Timeout on a load: memory never answers.
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd12, TIMEOUT + 3, 32'h1111_2222);
        // Ack on the very last allowed cycle.
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 5'd13, TIMEOUT, 32'h7777_0001);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            int op;
            logic rw, mtr, mw;
            op  = $urandom_range(0, 2);
            rw  = 1'($urandom_range(0, 1));
            mtr = (op == 1) ? 1'b1 : ((op == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
            mw  = (op == 2);
            issue(rw, mtr, mw, $urandom, $urandom, 5'($urandom),
                  $urandom_range(1, TIMEOUT + 2), $urandom);
        end

        @(posedge CLK);
        zero_m();
        #1;
        chk("queue_drained", WIDTH'(exp_q.size()), '0);
        chk("req_pulses", WIDTH'(req_pulses), WIDTH'(mem_ops));

        // Reset in the middle of an access.
        sb_en = 0;
        exp_q.delete();
        @(posedge CLK);
        REG_WRITE_M  = 1'b1;
        MEM_TO_REG_M = 1'b1;
        ALU_OUT_M    = 32'h0000_0A00;
        WRITE_REG_M  = 5'd5;
        exp_addr     = 32'h0000_0A00;
        exp_wdata    = '0;
        exp_we       = 1'b0;
        resp_k       = 1000;
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_clr_req", WIDTH'(MEM_REQ), 1);
        resp_en = 0;
        MEM_ACK = 1'b0;
        CLR = 1'b1;
        zero_m();
        #1;
        chk("clr_req", WIDTH'(MEM_REQ), '0);
        chk("clr_stall", WIDTH'(STALL_M), '0);
        chk("clr_err", WIDTH'(ERR), '0);
        chk("clr_addr", MEM_ADDR, '0);
        check_w_zero("clr_w");
        @(posedge CLK);
        CLR       = 1'b0;
        MEM_ACK   = 1'b1;
        MEM_RDATA = 32'hFFFF_FFFF;
        @(posedge CLK);
        MEM_ACK = 1'b0;
        @(posedge CLK);
        #1;
        chk("late_ack_req", WIDTH'(MEM_REQ), '0);
        chk("late_ack_stall", WIDTH'(STALL_M), '0);
        chk("late_ack_err", WIDTH'(ERR), '0);
        check_w_zero("late_ack_w");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
